// File: rtl/ex_muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer beside the EX stage; owns HI/LO.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up at the end.
module ex_muldiv_sequencer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [1:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_operand_a,
   input  logic [DATA_WIDTH-1:0] i_operand_b,
   input  logic                  i_flush,
   input  logic                  i_hi_we,
   input  logic                  i_lo_we,
   input  logic [DATA_WIDTH-1:0] i_hilo_wdata,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo,
   output logic                  o_div_by_zero
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned W2    = 2 * DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic            accept;
   logic            mt_open;
   logic [1:0]      op_q;
   logic [W-1:0]    a_q, b_q, opnd_q;
   logic [W2-1:0]   acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic            neg_lo_q, neg_hi_q;
   logic [W-1:0]    hi_q, lo_q;
   logic            busy_q, done_q, dbz_q;

   logic            is_div, is_signed, b_zero;
   logic [W-1:0]    a_abs, b_abs;
   logic [W:0]      mul_sum, rem_sh, div_diff;
   logic            div_ge;
   logic [W-1:0]    new_rem;
   logic [W2-1:0]   mul_next, div_next, prod_fix;
   logic [W-1:0]    q_fix, r_fix;

   // Datapath: magnitudes, one iteration step, and final sign fix-up
   always_comb begin
      is_div    = op_q[1];
      is_signed = ~op_q[0];
      b_zero    = (b_q == W'(0));
      a_abs     = (is_signed && a_q[W-1]) ? (~a_q + W'(1)) : a_q;
      b_abs     = (is_signed && b_q[W-1]) ? (~b_q + W'(1)) : b_q;
      mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
      mul_next  = {mul_sum, acc_q[W-1:1]};
      rem_sh    = acc_q[W2-1:W-1];
      div_diff  = rem_sh - {1'b0, opnd_q};
      div_ge    = (rem_sh >= {1'b0, opnd_q});
      new_rem   = div_ge ? div_diff[W-1:0] : rem_sh[W-1:0];
      div_next  = {new_rem, acc_q[W-2:0], div_ge};
      prod_fix  = neg_lo_q ? (~acc_q + W2'(1)) : acc_q;
      q_fix     = neg_lo_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
      r_fix     = neg_hi_q ? (~acc_q[W2-1:W] + W'(1)) : acc_q[W2-1:W];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_n;
   end

   // Flush wins over everything except in IDLE, where it is a no-op
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      mt_open = (state == S_IDLE) || (state == S_DONE);
      case (state)
         S_IDLE: if (i_start) begin
            state_n = S_PREP;
            accept  = 1'b1;
         end
         S_PREP: begin
            if (i_flush)               state_n = S_IDLE;
            else if (is_div && b_zero) state_n = S_DONE;
            else                       state_n = S_RUN;
         end
         S_RUN: begin
            if (i_flush)                               state_n = S_IDLE;
            else if (cnt_q == CNT_W'(DATA_WIDTH - 1))  state_n = S_FIX;
         end
         S_FIX:  state_n = i_flush ? S_IDLE : S_DONE;
         S_DONE: begin
            if (i_flush) state_n = S_IDLE;
            else if (i_start) begin
               state_n = S_PREP;
               accept  = 1'b1;
            end else state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         op_q     <= 2'b00;
         a_q      <= W'(0);
         b_q      <= W'(0);
         opnd_q   <= W'(0);
         acc_q    <= W2'(0);
         cnt_q    <= CNT_W'(0);
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= W'(0);
         lo_q     <= W'(0);
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         if (accept) begin
            op_q  <= i_op;
            a_q   <= i_operand_a;
            b_q   <= i_operand_b;
            dbz_q <= 1'b0;
         end
         if (mt_open && i_hi_we) hi_q <= i_hilo_wdata;
         if (mt_open && i_lo_we) lo_q <= i_hilo_wdata;
         case (state)
            S_PREP: if (!i_flush) begin
               cnt_q    <= CNT_W'(0);
               neg_lo_q <= is_signed && (a_q[W-1] ^ b_q[W-1]);
               neg_hi_q <= is_signed && a_q[W-1];
               if (is_div) begin
                  opnd_q <= b_abs;
                  acc_q  <= {W'(0), a_abs};
                  if (b_zero) begin
                     hi_q  <= a_q;
                     lo_q  <= '1;
                     dbz_q <= 1'b1;
                  end
               end else begin
                  opnd_q <= a_abs;
                  acc_q  <= {W'(0), b_abs};
               end
            end
            S_RUN: begin
               acc_q <= is_div ? div_next : mul_next;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            S_FIX: if (!i_flush) begin
               hi_q <= is_div ? r_fix : prod_fix[W2-1:W];
               lo_q <= is_div ? q_fix : prod_fix[W-1:0];
            end
            default: ;
         endcase
         busy_q <= (state_n == S_PREP) || (state_n == S_RUN) || (state_n == S_FIX);
         done_q <= (state_n == S_DONE);
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_hi          = hi_q;
   assign o_lo          = lo_q;
   assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: cycle-count/arithmetic reference model checked every
// cycle, directed scenarios with literal results, then a randomized soak.
module tb_ex_muldiv_sequencer;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [1:0]  i_op;
   logic [31:0] i_operand_a, i_operand_b;
   logic        i_flush, i_hi_we, i_lo_we;
   logic [31:0] i_hilo_wdata;
   logic        o_busy, o_done, o_div_by_zero;
   logic [31:0] o_hi, o_lo;

   int n_pass = 0;
   int n_total = 0;

   ex_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
      .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .i_flush(i_flush),
      .i_hi_we(i_hi_we), .i_lo_we(i_lo_we), .i_hilo_wdata(i_hilo_wdata),
      .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo),
      .o_div_by_zero(o_div_by_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Architectural result {div_by_zero, HI, LO} from plain arithmetic
   function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = 64'(sa * sb); return {1'b0, p}; end
         2'b01: begin p = {32'h0, a} * {32'h0, b}; return {1'b0, p}; end
         2'b10: begin
            if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, 32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
      endcase
   endfunction

   // Model: m_k is the cycle number since the accepting edge (0 = idle); DONE is cycle m_len
   int          m_k, m_len;
   logic [31:0] m_hi, m_lo;
   logic        m_dbz;
   logic [64:0] m_res;

   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         m_k <= 0; m_len <= 0; m_hi <= 32'h0; m_lo <= 32'h0; m_dbz <= 1'b0; m_res <= 65'h0;
      end else begin
         if (m_k == 0 || m_k == m_len) begin
            if (i_hi_we) m_hi <= i_hilo_wdata;
            if (i_lo_we) m_lo <= i_hilo_wdata;
         end
         if (m_k == 0 || (m_k == m_len && !i_flush)) begin
            if (i_start) begin
               m_k   <= 1;
               m_len <= (i_op[1] && i_operand_b == 32'h0) ? 2 : 35;
               m_res <= ref_result(i_op, i_operand_a, i_operand_b);
               m_dbz <= 1'b0;
            end else m_k <= 0;
         end else if (i_flush) m_k <= 0;
         else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_len) begin
               m_dbz <= m_res[64];
               m_hi  <= m_res[63:32];
               m_lo  <= m_res[31:0];
            end
         end
      end
   end

   always @(negedge i_clk) begin
      if (!i_reset) begin
         chk("busy", 32'(o_busy), 32'(m_k >= 1 && m_k < m_len));
         chk("done", 32'(o_done), 32'(m_k != 0 && m_k == m_len));
         chk("hi", o_hi, m_hi);
         chk("lo", o_lo, m_lo);
         chk("div_by_zero", 32'(o_div_by_zero), 32'(m_dbz));
      end
   end

   // Called at a falling edge; returns at the falling edge of cycle 1
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      i_start = 1'b1; i_op = op; i_operand_a = a; i_operand_b = b;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int busy_n);
      cyc = 1; busy_n = 0;
      while (o_done !== 1'b1 && cyc < 200) begin
         if (o_busy) busy_n++;
         @(negedge i_clk);
         cyc++;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int cyc, busy_n;
      logic [64:0] r;
      i_reset = 1'b0; i_start = 1'b0; i_op = 2'b00; i_operand_a = 32'h0; i_operand_b = 32'h0;
      i_flush = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0; i_hilo_wdata = 32'h0;

      r = ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("model_div_ovf_lo", r[31:0], 32'h8000_0000);
      chk("model_div_ovf_hi", r[63:32], 32'h0);
      r = ref_result(2'b10, 32'hFFFF_FFF9, 32'd2);
      chk("model_div_neg_lo", r[31:0], 32'hFFFF_FFFD);
      chk("model_div_neg_hi", r[63:32], 32'hFFFF_FFFF);

      #1 i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("reset_busy", 32'(o_busy), 32'h0);
      chk("reset_hi", o_hi, 32'h0);
      chk("reset_lo", o_lo, 32'h0);
      #2 i_reset = 1'b0;
      @(negedge i_clk);

      start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
      wait_done(cyc, busy_n);
      chk("mult_done_cycle", 32'(cyc), 32'd35);
      chk("mult_busy_cycles", 32'(busy_n), 32'd34);
      chk("mult_hi", o_hi, 32'hFFFF_FFFF);
      chk("mult_lo", o_lo, 32'hFFFF_FFF1);

      @(negedge i_clk);
      start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, busy_n);
      chk("multu_hi", o_hi, 32'hFFFF_FFFE);
      chk("multu_lo", o_lo, 32'h0000_0001);
      start_op(2'b01, 32'd2, 32'd3);
      wait_done(cyc, busy_n);
      chk("b2b_done_cycle", 32'(cyc), 32'd35);
      chk("b2b_hi", o_hi, 32'h0);
      chk("b2b_lo", o_lo, 32'd6);

      start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_done(cyc, busy_n);
      chk("div_neg_lo", o_lo, 32'hFFFF_FFFD);
      chk("div_neg_hi", o_hi, 32'hFFFF_FFFF);
      start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc, busy_n);
      chk("div_ovf_lo", o_lo, 32'h8000_0000);
      chk("div_ovf_hi", o_hi, 32'h0);
      start_op(2'b11, 32'd100, 32'd7);
      wait_done(cyc, busy_n);
      chk("divu_lo", o_lo, 32'd14);
      chk("divu_hi", o_hi, 32'd2);

      start_op(2'b11, 32'd7, 32'd0);
      wait_done(cyc, busy_n);
      chk("dbz_done_cycle", 32'(cyc), 32'd2);
      chk("dbz_hi", o_hi, 32'd7);
      chk("dbz_lo", o_lo, 32'hFFFF_FFFF);
      chk("dbz_flag", 32'(o_div_by_zero), 32'h1);
      start_op(2'b00, 32'd4, 32'd5);
      chk("dbz_cleared", 32'(o_div_by_zero), 32'h0);
      wait_done(cyc, busy_n);
      chk("mult_after_dbz_lo", o_lo, 32'd20);

      @(negedge i_clk);
      i_hi_we = 1'b1; i_lo_we = 1'b1; i_hilo_wdata = 32'h1111_1111;
      @(negedge i_clk);
      i_hi_we = 1'b0; i_lo_we = 1'b0;
      start_op(2'b00, 32'd7, 32'd9);
      repeat (9) @(negedge i_clk);
      i_flush = 1'b1;
      @(negedge i_clk);
      i_flush = 1'b0;
      chk("flush_busy", 32'(o_busy), 32'h0);
      chk("flush_hi", o_hi, 32'h1111_1111);
      chk("flush_lo", o_lo, 32'h1111_1111);
      repeat (3) begin
         chk("flush_no_done", 32'(o_done), 32'h0);
         @(negedge i_clk);
      end

      start_op(2'b10, 32'hFFFF_FF9C, 32'd3);
      repeat (19) @(negedge i_clk);
      #2 i_reset = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(o_busy), 32'h0);
      chk("rst_mid_done", 32'(o_done), 32'h0);
      chk("rst_mid_hi", o_hi, 32'h0);
      chk("rst_mid_lo", o_lo, 32'h0);
      chk("rst_mid_dbz", 32'(o_div_by_zero), 32'h0);
      @(negedge i_clk);
      #2 i_reset = 1'b0;
      @(negedge i_clk);

      start_op(2'b01, 32'd3, 32'd4);
      repeat (4) @(negedge i_clk);
      i_hi_we = 1'b1; i_hilo_wdata = 32'hA5A5_A5A5;
      @(negedge i_clk);
      i_hi_we = 1'b0;
      wait_done(cyc, busy_n);
      chk("mt_busy_hi", o_hi, 32'h0);
      chk("mt_busy_lo", o_lo, 32'd12);
      @(negedge i_clk);
      i_lo_we = 1'b1; i_hilo_wdata = 32'h5A5A_5A5A;
      @(negedge i_clk);
      i_lo_we = 1'b0;
      chk("mtlo_idle", o_lo, 32'h5A5A_5A5A);
      chk("mtlo_idle_hi", o_hi, 32'h0);

      for (int i = 0; i < 6000; i++) begin
         i_start      = ($urandom_range(0, 9) == 0);
         i_op         = 2'($urandom_range(0, 3));
         i_operand_a  = pick();
         i_operand_b  = pick();
         i_flush      = ($urandom_range(0, 79) == 0);
         i_hi_we      = ($urandom_range(0, 7) == 0);
         i_lo_we      = ($urandom_range(0, 7) == 0);
         i_hilo_wdata = $urandom;
         @(negedge i_clk);
      end
      i_start = 1'b0; i_flush = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
      repeat (40) @(negedge i_clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
